// File: rtl/demux2_route_if.sv
// Handshake bundle for the 1-to-2 router: one producer side, two consumer
// channels, and the per-channel delivered-word counters.
interface demux2_route_if #(
   parameter int WIDTH = 2,
   parameter int CNT_W = 8
);
   logic             addr;
   logic [WIDTH-1:0] din;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out0_data;
   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out1_data;
   logic             out1_valid;
   logic             out1_ready;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   modport master (
      output addr, din, in_valid, out0_ready, out1_ready,
      input  in_ready, out0_data, out0_valid,
      input  out1_data, out1_valid, cnt0, cnt1
   );

   modport slave (
      input  addr, din, in_valid, out0_ready, out1_ready,
      output in_ready, out0_data, out0_valid,
      output out1_data, out1_valid, cnt0, cnt1
   );
endinterface

// File: rtl/demux2_route.sv
// 1-to-2 demultiplexer: steers each word by its address bit into one of two
// independent output FIFOs, each with its own delivered-word counter.
module demux2_route #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   demux2_route_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = PW + 1;

   logic [1:0]       full;
   logic [1:0]       valid;
   logic [1:0]       rdy;
   logic [1:0]       push;
   logic [1:0]       pop;
   logic [WIDTH-1:0] head [2];
   logic [CNT_W-1:0] cnt  [2];
   logic             in_fire;

   assign bus.in_ready = rst_n && !full[bus.addr];
   assign in_fire      = bus.in_valid && bus.in_ready;
   assign rdy          = {bus.out1_ready, bus.out0_ready};

   for (genvar c = 0; c < 2; c++) begin : g_ch
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [WIDTH-1:0] mem_d [DEPTH];
      logic [PW-1:0]    wptr_q, wptr_d;
      logic [PW-1:0]    rptr_q, rptr_d;
      logic [OW-1:0]    occ_q, occ_d;
      logic [WIDTH-1:0] head_q, head_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      assign full[c]  = (occ_q == OW'(DEPTH));
      assign valid[c] = (occ_q != '0);
      assign push[c]  = in_fire && (bus.addr == (c == 1));
      assign pop[c]   = valid[c] && rdy[c];
      assign head[c]  = head_q;
      assign cnt[c]   = cnt_q;

      always_comb begin
         mem_d  = mem_q;
         wptr_d = wptr_q;
         rptr_d = rptr_q;
         head_d = head_q;
         if (push[c]) begin
            mem_d[wptr_q] = bus.din;
            wptr_d        = wptr_q + PW'(1);
         end
         if (pop[c]) begin
            rptr_d = rptr_q + PW'(1);
         end
         occ_d = occ_q + OW'(push[c]) - OW'(pop[c]);
         cnt_d = cnt_q + CNT_W'(pop[c]);
         // Head comes from the post-write array, so a push into an
         // emptying FIFO lands in the head register directly.
         if (occ_d != '0) begin
            head_d = mem_d[rptr_d];
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            head_q <= '0;
            cnt_q  <= '0;
         end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            head_q <= head_d;
            cnt_q  <= cnt_d;
         end
      end
   end

   assign bus.out0_data  = head[0];
   assign bus.out0_valid = valid[0];
   assign bus.out1_data  = head[1];
   assign bus.out1_valid = valid[1];
   assign bus.cnt0       = cnt[0];
   assign bus.cnt1       = cnt[1];
endmodule

// File: doc/demux2_route.md
Name: demux2_route

Overview:
- Sequential 1-to-2 demultiplexer; the inverse of the team's 2:1 selector. One input word carries a 1-bit address, and the block steers it to output channel 0 or 1.
- Each output channel has its own small FIFO, so a stalled consumer on one side never corrupts the other side's data.
- Valid/ready handshakes on the input and on both outputs, plus a per-channel delivered-word counter for debug and verification.
- Sits between a single producer and two independent consumers in the selector datapath.

Parameters:
- WIDTH, 2, data word width in bits.
- DEPTH, 2, entries per output FIFO; power of two, ≥2.
- CNT_W, 8, width of each delivered-word counter.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- addr  in  1  destination select: 0 routes to out0, 1 routes to out1.
- din  in  WIDTH  data word to route.
- in_valid  in  1  producer offers {addr, din} this cycle.
- in_ready  out  1  block can accept the offered word this cycle.
- out0_data  out  WIDTH  head word of channel-0 FIFO.
- out0_valid  out  1  channel-0 FIFO not empty.
- out0_ready  in  1  consumer 0 takes the head word.
- out1_data  out  WIDTH  head word of channel-1 FIFO.
- out1_valid  out  1  channel-1 FIFO not empty.
- out1_ready  in  1  consumer 1 takes the head word.
- cnt0  out  CNT_W  words delivered on channel 0.
- cnt1  out  CNT_W  words delivered on channel 1.

Behaviour:
- Reset, with rst_n low at a clock edge:
  - Both FIFOs become empty; pointers and occupancy go to 0.
  - outN_valid=0, outN_data=0, cnt0=cnt1=0.
  - Reset mid-transfer discards all stored words. No handshake completes on the reset edge.
  - in_ready is held 0 while rst_n is low.
- in_ready is combinational: !full[addr] when rst_n is high. It does not depend on in_valid. It may depend on addr; the producer must hold addr/din stable while in_valid is high and in_ready is low.
- Push: when in_valid && in_ready, din is written to FIFO[addr] at the tail.
  - The word is visible on outN_data with outN_valid=1 in the next cycle.
  - Input-to-output latency is 1 cycle when the FIFO was empty.
- Pop on channel N: when outN_valid && outN_ready, the head is removed. The next entry (or nothing) presents in the following cycle, and cntN increments by 1.
- outN_data is driven from the FIFO head register. When empty, it holds its last value (0 after reset); it is don't-care while outN_valid=0, and the bench must not check it then.
- Ordering: words on the same channel leave in FIFO order. There is no ordering relation between the two channels.
- Simultaneous push and pop on the same channel in one cycle:
  - Occupancy is unchanged.
  - If the FIFO is full, in_ready=0, so no push occurs (no same-cycle bypass).
  - If the FIFO has one entry, the pushed word becomes the head the next cycle.
- Push to one channel and pop from the other in the same cycle are fully independent.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. A separate occupancy count (0..DEPTH) distinguishes full from empty.
- Counters wrap from 2^CNT_W−1 to 0 silently; no saturation, no flag.
- outN_ready while outN_valid=0: ignored; no counter change.

Test Plan:
- Reset, then addr=1, din=2'b01, in_valid=1 for one cycle, out1_ready=0:
  - in_ready=1; next cycle out1_valid=1, out1_data=01, out0_valid=0.
- Fill channel 0: push 2'b01 then 2'b10 with out0_ready=0:
  - After two accepts, in_ready=0 for addr=0 and stays 1 for addr=1.
  - Raise out0_ready: words 01 then 10 are delivered in order, and cnt0 ends at 2.
- Full channel 0 with DEPTH=2, out0_ready=1 and in_valid=1, addr=0, din=2'b11 in the same cycle:
  - No accept that cycle (in_ready=0).
  - The next cycle accepts it; final delivery order is 01, 10, 11.
- Interleave addr=0/din=2'b00, addr=1/din=2'b01, addr=0/din=2'b10 with both ready=1:
  - out0 sees 00, 10; out1 sees 01.
  - cnt0=2, cnt1=1, with no stalls (in_ready constantly 1).
- With CNT_W=8, deliver 257 words on channel 1:
  - cnt1 reads 1 after wrap; cnt0 stays 0.
- Assert rst_n=0 with both FIFOs holding data:
  - Next cycle out0_valid=out1_valid=0, cnt0=cnt1=0, in_ready=0 while reset is held.
  - The first push after release is delivered normally.
